// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types for the sequential square-root block
// Purpose: FSM state encoding used by sqrt_sequential_unrolled.
// Ports: none (package).
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    COMP = 2'b01,
    DONE = 2'b11
  } sqrt_state_t;

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational non-restoring square-root iteration
// Purpose: consumes two radicand bits, updates partial remainder and root.
// Ports:
//   r_in  - signed partial remainder in (N/2+2 bits)
//   q_in  - partial root in (N/2 bits)
//   d     - next two radicand bits, MSB first
//   r_out - signed partial remainder out
//   q_out - partial root out, new bit appended at LSB
module sqrt_step #(
  parameter int N = 16
) (
  input  logic signed [N/2+1:0] r_in,
  input  logic        [N/2-1:0] q_in,
  input  logic        [1:0]     d,
  output logic signed [N/2+1:0] r_out,
  output logic        [N/2-1:0] q_out
);

  localparam int HW = N / 2;
  localparam int RW = HW + 2;

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;

  // Arithmetic is done modulo 2^RW: the true result always fits in RW
  // signed bits, so the top two bits of r_in shifted out here are redundant.
  always_comb begin
    shifted = {r_in[RW-3:0], d};
    if (r_in[RW-1]) begin
      trial = shifted + {q_in, 2'b11};
    end else begin
      trial = shifted - {q_in, 2'b01};
    end
    r_out = trial;
    q_out = {q_in[HW-2:0], ~trial[RW-1]};
  end

  // Root MSB is always zero before the last shift; remainder bit RW-2 only
  // matters through the modular arithmetic above.
  logic unused_bits;
  assign unused_bits = ^{r_in[RW-2], q_in[HW-1]};

endmodule

// File: rtl/sqrt_sequential_unrolled.sv
// rtl/sqrt_sequential_unrolled.sv - multi-cycle unsigned integer square root
// Purpose: floor(sqrt(num)) and remainder, STEPS non-restoring iterations per
// clock, valid/ready handshakes on both sides, one operation in flight.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   num_vld - radicand valid
//   num_rdy - block can accept a radicand (IDLE only)
//   num     - unsigned radicand, N bits
//   res_vld - result valid (DONE only)
//   res_rdy - downstream accepts the result
//   res     - floor(sqrt(num)), N/2 bits
//   rem     - num - res*res, N/2+1 bits
module sqrt_sequential_unrolled
  import sqrt_pkg::*;
#(
  parameter int N     = 16,
  parameter int STEPS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           num_vld,
  output logic           num_rdy,
  input  logic [N-1:0]   num,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [N/2-1:0] res,
  output logic [N/2:0]   rem
);

  localparam int HW   = N / 2;
  localparam int RW   = HW + 2;
  localparam int ITER = N / (2 * STEPS);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  if ((N < 4) || (N % 2 != 0) || (STEPS < 1) || (HW % STEPS != 0) ||
      ((STEPS & (STEPS - 1)) != 0)) begin : g_param_check
    $error("sqrt_sequential_unrolled: illegal N/STEPS combination");
  end

  sqrt_state_t        state, state_nxt;
  logic [N-1:0]       num_sh;
  logic signed [RW-1:0] r_reg;
  logic [HW-1:0]      q_reg;
  logic [CW-1:0]      cnt;
  logic [HW-1:0]      res_q;
  logic [HW:0]        rem_q;
  logic               num_rdy_q;
  logic               res_vld_q;

  logic               accept;
  logic               last;

  logic signed [RW-1:0] r_ch [STEPS+1];
  logic [HW-1:0]        q_ch [STEPS+1];
  logic [RW-1:0]        rem_fix;

  assign accept = num_vld && num_rdy_q;
  assign last   = (cnt == CW'(ITER - 1));

  // Unrolled iteration chain; step i consumes bit pair i from the top.
  assign r_ch[0] = r_reg;
  assign q_ch[0] = q_reg;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    sqrt_step #(.N(N)) u_step (
      .r_in  (r_ch[i]),
      .q_in  (q_ch[i]),
      .d     (num_sh[N-1-2*i -: 2]),
      .r_out (r_ch[i+1]),
      .q_out (q_ch[i+1])
    );
  end

  // A negative final remainder is off by exactly 2*root+1; the corrected
  // value lies in [0, 2*root] and fits in N/2+1 bits.
  always_comb begin
    if (r_ch[STEPS][RW-1]) begin
      rem_fix = r_ch[STEPS] + {1'b0, q_ch[STEPS], 1'b1};
    end else begin
      rem_fix = r_ch[STEPS];
    end
  end

  logic unused_rem;
  assign unused_rem = rem_fix[RW-1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMP;
      COMP:    if (last) state_nxt = DONE;
      DONE:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered so reset can hold num_rdy low while the
  // state already reads IDLE; they otherwise track the next state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      num_rdy_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      num_rdy_q <= (state_nxt == IDLE);
      res_vld_q <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_sh <= '0;
      r_reg  <= '0;
      q_reg  <= '0;
      cnt    <= '0;
      res_q  <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            num_sh <= num;
            r_reg  <= '0;
            q_reg  <= '0;
            cnt    <= '0;
          end
        end
        COMP: begin
          num_sh <= num_sh << (2 * STEPS);
          r_reg  <= r_ch[STEPS];
          q_reg  <= q_ch[STEPS];
          if (last) begin
            res_q <= q_ch[STEPS];
            rem_q <= rem_fix[HW:0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign num_rdy = num_rdy_q;
  assign res_vld = res_vld_q;
  assign res     = res_q;
  assign rem     = rem_q;

endmodule

// File: tb/tb_sqrt_sequential_unrolled.sv
// tb/tb_sqrt_sequential_unrolled.sv - self-checking bench for sqrt_sequential_unrolled
module tb_sqrt_sequential_unrolled;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        num_vld = 1'b0;
  logic        res_rdy = 1'b0;
  logic [15:0] num = '0;
  logic [31:0] num32 = '0;

  // Lanes 0..2: N=16 with STEPS 1, 4, 8. Lane 3: N=32 with STEPS 4.
  logic [2:0]  num_rdy_a, res_vld_a;
  logic [7:0]  res_a [3];
  logic [8:0]  rem_a [3];
  logic        num_rdy_w, res_vld_w;
  logic [15:0] res_w;
  logic [16:0] rem_w;

  int checks = 0;
  int errors = 0;
  bit soak_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sqrt_sequential_unrolled #(
      .N(16), .STEPS((g == 0) ? 1 : (g == 1) ? 4 : 8)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .num_vld(num_vld), .num_rdy(num_rdy_a[g]),
      .num(num), .res_vld(res_vld_a[g]), .res_rdy(res_rdy),
      .res(res_a[g]), .rem(rem_a[g])
    );
  end

  sqrt_sequential_unrolled #(.N(32), .STEPS(4)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .num_vld(num_vld), .num_rdy(num_rdy_w),
    .num(num32), .res_vld(res_vld_w), .res_rdy(res_rdy),
    .res(res_w), .rem(rem_w)
  );

  function automatic longint lane_res(int i);
    return (i < 3) ? longint'(res_a[i]) : longint'(res_w);
  endfunction
  function automatic longint lane_rem(int i);
    return (i < 3) ? longint'(rem_a[i]) : longint'(rem_w);
  endfunction
  function automatic logic lane_vld(int i);
    return (i < 3) ? res_vld_a[i] : res_vld_w;
  endfunction
  function automatic logic lane_rdy(int i);
    return (i < 3) ? num_rdy_a[i] : num_rdy_w;
  endfunction

  // Binary-search reference for floor(sqrt(x)).
  function automatic longint isqrt(longint x);
    longint lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid; else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Latency counted in edges including the acceptance edge: ITER+1.
  int lat_exp [4] = '{9, 3, 2, 5};

  task automatic run_vec(input logic [15:0] v, input longint er, input longint em,
                         input string tag, input bit hold);
    int lat [4];
    int edges;
    bit all_done;
    lat = '{0, 0, 0, 0};
    @(negedge clk);
    num = v; num32 = {16'h0, v}; num_vld = 1'b1; res_rdy = 1'b0;
    @(posedge clk);
    #1 num_vld = 1'b0; num = 16'($urandom); num32 = $urandom;
    edges = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (lane_vld(i) && lat[i] == 0) lat[i] = edges;
        if (lat[i] == 0) all_done = 1'b0;
      end
      if (all_done) break;
      @(posedge clk);
      edges++;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s lane%0d res", tag, i), lane_res(i), er);
      check($sformatf("%s lane%0d rem", tag, i), lane_rem(i), em);
      check($sformatf("%s lane%0d latency", tag, i), lat[i], lat_exp[i]);
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1 num_vld = k[0]; num = 16'($urandom); num32 = $urandom;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          check($sformatf("%s hold%0d lane%0d vld", tag, k, i), lane_vld(i), 1);
          check($sformatf("%s hold%0d lane%0d rdy", tag, k, i), lane_rdy(i), 0);
          check($sformatf("%s hold%0d lane%0d res", tag, k, i), lane_res(i), er);
          check($sformatf("%s hold%0d lane%0d rem", tag, k, i), lane_rem(i), em);
        end
      end
      num_vld = 1'b0;
    end
    @(negedge clk);
    res_rdy = 1'b1;
    @(posedge clk);
    #1 res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s lane%0d vld after rdy", tag, i), lane_vld(i), 0);
      check($sformatf("%s lane%0d idle after rdy", tag, i), lane_rdy(i), 1);
    end
  endtask

  typedef struct {
    logic [15:0] num;
    longint      res;
    longint      rem;
  } vec_t;

  vec_t vecs [10];

  // Soak scoreboard: one operation in flight per lane.
  longint exp_res [4];
  longint exp_rem [4];
  bit     pend [4];
  int     done_cnt [4];

  always @(negedge clk) begin
    if (soak_on) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_vld(i) && res_rdy) begin
          check($sformatf("soak lane%0d pending", i), pend[i], 1);
          check($sformatf("soak lane%0d res", i), lane_res(i), exp_res[i]);
          check($sformatf("soak lane%0d rem", i), lane_rem(i), exp_rem[i]);
          pend[i] = 1'b0;
          done_cnt[i]++;
        end
        if (num_vld && lane_rdy(i)) begin
          longint x;
          x = (i < 3) ? longint'(num) : longint'(num32);
          exp_res[i] = isqrt(x);
          exp_rem[i] = x - exp_res[i] * exp_res[i];
          pend[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    vecs[0] = '{16'd0,     0,   0};
    vecs[1] = '{16'd65535, 255, 510};
    vecs[2] = '{16'd144,   12,  0};
    vecs[3] = '{16'd2,     1,   1};
    vecs[4] = '{16'd1,     1,   0};
    vecs[5] = '{16'd3,     1,   2};
    vecs[6] = '{16'd255,   15,  30};
    vecs[7] = '{16'd256,   16,  0};
    vecs[8] = '{16'd65024, 254, 508};
    vecs[9] = '{16'd1000,  31,  39};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset lane%0d rdy", i), lane_rdy(i), 0);
      check($sformatf("reset lane%0d vld", i), lane_vld(i), 0);
      check($sformatf("reset lane%0d res", i), lane_res(i), 0);
      check($sformatf("reset lane%0d rem", i), lane_rem(i), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("first edge lane%0d rdy", i), lane_rdy(i), 1);

    for (int v = 0; v < 10; v++)
      run_vec(vecs[v].num, vecs[v].res, vecs[v].rem, $sformatf("vec%0d", v), v == 1);

    // Reset between edges while lanes are mid-COMP (STEPS 1, N=32) or in DONE.
    @(negedge clk);
    num = 16'd200; num32 = 32'd200; num_vld = 1'b1; res_rdy = 1'b0;
    @(posedge clk);
    #1 num_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midreset lane%0d rdy", i), lane_rdy(i), 0);
      check($sformatf("midreset lane%0d vld", i), lane_vld(i), 0);
      check($sformatf("midreset lane%0d res", i), lane_res(i), 0);
      check($sformatf("midreset lane%0d rem", i), lane_rem(i), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        check($sformatf("post-reset lane%0d no output", i), lane_vld(i), 0);
    end
    run_vec(16'd81, 9, 0, "after reset", 1'b0);

    // Random soak with valid/ready stalls.
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      done_cnt[i] = 0;
    end
    soak_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      num_vld = ($urandom_range(0, 2) != 0);
      res_rdy = ($urandom_range(0, 3) != 0);
      num32 = $urandom;
      case ($urandom_range(0, 9))
        0: num = 16'hFFFF;
        1: num = 16'h0000;
        default: num = num32[15:0];
      endcase
      if ($urandom_range(0, 19) == 0) num32 = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    soak_on = 1'b0;
    num_vld = 1'b0;
    for (int i = 0; i < 4; i++)
      check($sformatf("soak lane%0d completions", i), done_cnt[i] > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
